// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: Q4.28 angle table, pi, the CORDIC gain reciprocal
// and the FSM state type used by the vectoring unit.
package cordic_pkg;

    // Number of fractional bits in the Q4.28 format.
    localparam int FRAC = 28;

    // Depth of the arctangent table; also the largest legal iteration count.
    localparam int ATAN_DEPTH = 28;

    // pi in Q4.28.
    localparam logic signed [31:0] PI = 32'sh3243F6A8;

    // Reciprocal of the accumulated CORDIC gain (0.6072529) in Q4.28.
    localparam logic signed [31:0] K = 32'sh09B74EDA;

    // atan(2^-i) in Q4.28, rounded to nearest.
    localparam logic [31:0] ATAN [0:ATAN_DEPTH-1] = '{
        32'h0C90FDAA, 32'h076B19C1, 32'h03EB6EBF, 32'h01FD5BAA,
        32'h00FFAADE, 32'h007FF557, 32'h003FFEAB, 32'h001FFFD5,
        32'h000FFFFB, 32'h0007FFFF, 32'h00040000, 32'h00020000,
        32'h00010000, 32'h00008000, 32'h00004000, 32'h00002000,
        32'h00001000, 32'h00000800, 32'h00000400, 32'h00000200,
        32'h00000100, 32'h00000080, 32'h00000040, 32'h00000020,
        32'h00000010, 32'h00000008, 32'h00000004, 32'h00000002
    };

    // Sequencing of one vectoring request.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        SCALE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/cordic_atan_lut.sv
// Combinational arctangent table: iteration index -> atan(2^-idx) in Q4.28.
// Indices past the end of the table return zero.
module cordic_atan_lut
    import cordic_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [4:0]   idx,
    output logic [N-1:0] value
);

    // Table lookup with an in-range guard for the unused top indices.
    always_comb begin
        value = '0;
        if (idx <= 5'(ATAN_DEPTH - 1)) begin
            value = N'(ATAN[idx]);
        end
    end

endmodule

// File: rtl/cordic_vectoring_unit.sv
// Vectoring-mode CORDIC: converts (Xi, Yi) into magnitude and atan2 angle.
// One micro-rotation per clock; valid/ready handshakes on both sides.
module cordic_vectoring_unit
    import cordic_pkg::*;
#(
    parameter int N = 32,
    parameter int I = 28
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] Xi,
    input  logic [N-1:0] Yi,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] mag,
    output logic [N-1:0] angle
);

    // Internal datapath carries two guard bits above the port width.
    localparam int W  = N + 2;
    // Product width for the gain-compensation multiply.
    localparam int PW = W + N;

    localparam logic signed [W-1:0]  PI_W = W'(PI);
    localparam logic signed [PW-1:0] K_P  = PW'(K);

    state_t              state;
    state_t              state_next;
    logic [4:0]          iter_cnt;
    logic                last_iter;
    logic                zero_vec;

    logic signed [W-1:0] x;
    logic signed [W-1:0] y;
    logic signed [W-1:0] z;
    logic signed [W-1:0] xi_w;
    logic signed [W-1:0] yi_w;
    logic signed [W-1:0] x_shift;
    logic signed [W-1:0] y_shift;
    logic signed [W-1:0] atan_w;
    logic signed [PW-1:0] x_ext;
    logic [N-1:0]        atan_val;

    cordic_atan_lut #(
        .N (N)
    ) u_atan_lut (
        .idx   (iter_cnt),
        .value (atan_val)
    );

    assign xi_w      = W'(signed'(Xi));
    assign yi_w      = W'(signed'(Yi));
    assign x_shift   = x >>> iter_cnt;
    assign y_shift   = y >>> iter_cnt;
    assign atan_w    = W'(signed'(atan_val));
    assign x_ext     = PW'(x);
    assign last_iter = (iter_cnt == 5'(I - 1));

    // State register; reset returns to IDLE regardless of any handshake.
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and handshake outputs.
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = ITER;
                end
            end
            ITER: begin
                if (last_iter) begin
                    state_next = SCALE;
                end
            end
            SCALE: begin
                state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: quadrant pre-rotation at load, one micro-rotation per ITER
    // cycle, gain compensation in SCALE; results held through DONE.
    // NOTE: the x/y/z working registers are reset along with the outputs so an
    // aborted request leaves nothing behind; this is plain logic, not a memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            iter_cnt <= '0;
            zero_vec <= 1'b0;
            x        <= '0;
            y        <= '0;
            z        <= '0;
            mag      <= '0;
            angle    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        iter_cnt <= '0;
                        zero_vec <= (Xi == '0) && (Yi == '0);
                        if (!Xi[N-1]) begin
                            x <= xi_w;
                            y <= yi_w;
                            z <= '0;
                        end else begin
                            // Left half-plane: rotate by pi so x starts >= 0.
                            x <= -xi_w;
                            y <= -yi_w;
                            z <= Yi[N-1] ? -PI_W : PI_W;
                        end
                    end
                end
                ITER: begin
                    if (y[W-1]) begin
                        x <= x - y_shift;
                        y <= y + x_shift;
                        z <= z - atan_w;
                    end else begin
                        x <= x + y_shift;
                        y <= y - x_shift;
                        z <= z + atan_w;
                    end
                    iter_cnt <= iter_cnt + 5'd1;
                end
                SCALE: begin
                    if (zero_vec) begin
                        mag   <= '0;
                        angle <= '0;
                    end else begin
                        mag   <= N'((x_ext * K_P) >>> FRAC);
                        angle <= z[N-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_vectoring_unit.sv
// Self-checking bench for cordic_vectoring_unit: directed vectors, handshake
// and reset scenarios, then random vectors against a real-arithmetic model.
module tb_cordic_vectoring_unit;

    localparam int  N     = 32;
    localparam int  I     = 28;
    localparam int  TOL   = 16;
    localparam real TWO28 = 268435456.0;
    localparam real PI_R  = 3.14159265358979323846;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] Xi;
    logic [N-1:0] Yi;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] mag;
    logic [N-1:0] angle;

    int checks = 0;
    int errors = 0;

    cordic_vectoring_unit #(
        .N (N),
        .I (I)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Xi        (Xi),
        .Yi        (Yi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mag       (mag),
        .angle     (angle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input longint obs, input longint exp,
                         input longint tol = 0);
        longint d;
        checks++;
        d = obs - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) tol %0d",
                     tag, obs, obs[31:0], exp, exp[31:0], tol);
        end
    endtask

    function automatic int rnd(input real v);
        rnd = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    endfunction

    // Ideal magnitude and atan2 angle in Q4.28 LSBs; the zero vector is exact 0/0.
    function automatic void model(input int xi, input int yi, output int em, output int ea);
        real xr;
        real yr;
        if (xi == 0 && yi == 0) begin
            em = 0;
            ea = 0;
        end else begin
            xr = $itor(xi);
            yr = $itor(yi);
            em = rnd($sqrt(xr * xr + yr * yr));
            ea = rnd($atan2(yr, xr) * TWO28);
        end
    endfunction

    // Issue one request and wait (bounded) for the result to appear.
    task automatic run_req(input logic [N-1:0] xi, input logic [N-1:0] yi,
                           output logic [N-1:0] m, output logic [N-1:0] a,
                           output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        @(negedge clk);
        in_valid = 1'b1;
        Xi       = xi;
        Yi       = yi;
        @(posedge clk); #1;
        in_valid = 1'b0;
        Xi       = $urandom;
        Yi       = $urandom;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("out_valid_seen", longint'(out_valid), 1);
        m = mag;
        a = angle;
    endtask

    // Take the pending result with a one-cycle out_ready pulse.
    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("idle_after_take", longint'(in_ready), 1);
    endtask

    initial begin
        logic [N-1:0] m;
        logic [N-1:0] a;
        logic [N-1:0] m_hold;
        logic [N-1:0] a_hold;
        int           lat;
        int           em;
        int           ea;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        Xi        = '0;
        Yi        = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  longint'(in_ready), 1);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_mag",       longint'(mag), 0);
        check("rst_angle",     longint'(angle), 0);
        @(negedge clk);
        rst = 1'b0;

        // First quadrant diagonal, with latency.
        run_req(32'h0B504F33, 32'h0B504F33, m, a, lat);
        check("diag_latency", longint'(lat), I + 1);
        check("diag_mag",   longint'(m), 32'h10000000, TOL);
        check("diag_angle", longint'($signed(a)), longint'($signed(32'h0C90FDAA)), TOL);
        consume();

        // Negative x axis gives +pi.
        run_req(32'hF0000000, 32'h00000000, m, a, lat);
        check("negx_mag",   longint'(m), 32'h10000000, TOL);
        check("negx_angle", longint'($signed(a)), longint'($signed(32'h3243F6A8)), TOL);
        consume();

        // Fourth quadrant, -pi/3.
        run_req(32'h08000000, 32'hF224C28C, m, a, lat);
        check("q4_mag",   longint'(m), 32'h10000000, TOL);
        check("q4_angle", longint'($signed(a)), longint'($signed(32'hEF3EADC8)), TOL);
        consume();

        // Third quadrant, -2pi/3: exercises the pre-rotation.
        run_req(32'hF8000000, 32'hF224C28C, m, a, lat);
        check("q3_mag",   longint'(m), 32'h10000000, TOL);
        check("q3_angle", longint'($signed(a)), longint'($signed(32'hDE7D5B90)), TOL);
        consume();

        // Zero vector is exact.
        run_req(32'h00000000, 32'h00000000, m, a, lat);
        check("zero_mag",   longint'(m), 0);
        check("zero_angle", longint'($signed(a)), 0);
        consume();

        // Backpressure: result and flags held for 5 cycles.
        run_req(32'h12345678, 32'hF3210FED, m, a, lat);
        model(32'h12345678, 32'hF3210FED, em, ea);
        check("bp_mag",   longint'(m), longint'(em), TOL);
        check("bp_angle", longint'($signed(a)), longint'(ea), TOL);
        m_hold = m;
        a_hold = a;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp_out_valid", longint'(out_valid), 1);
            check("bp_in_ready",  longint'(in_ready), 0);
            check("bp_mag_hold",  longint'(mag), longint'(m_hold));
            check("bp_ang_hold",  longint'(angle), longint'(a_hold));
        end
        consume();

        // Reset while iterating (counter at 10).
        @(negedge clk);
        in_valid = 1'b1;
        Xi       = 32'h10000000;
        Yi       = 32'h10000000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid_busy", longint'(in_ready), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_out_valid", longint'(out_valid), 0);
        check("mid_rst_in_ready",  longint'(in_ready), 1);
        check("mid_rst_mag",       longint'(mag), 0);
        check("mid_rst_angle",     longint'(angle), 0);
        @(negedge clk);
        rst = 1'b0;

        // Fresh request after the abort.
        run_req(32'h08000000, 32'hF224C28C, m, a, lat);
        check("post_rst_latency", longint'(lat), I + 1);
        check("post_rst_mag",   longint'(m), 32'h10000000, TOL);
        check("post_rst_angle", longint'($signed(a)), longint'($signed(32'hEF3EADC8)), TOL);
        consume();

        // Random vectors, magnitude 0.25..4.5, any angle.
        for (int n = 0; n < 24; n++) begin
            real r;
            real th;
            int  xi;
            int  yi;
            r  = 0.25 + 4.25 * $itor($urandom_range(0, 100000)) / 100000.0;
            th = PI_R * (2.0 * $itor($urandom_range(0, 100000)) / 100000.0 - 1.0);
            xi = $rtoi(r * $cos(th) * TWO28);
            yi = $rtoi(r * $sin(th) * TWO28);
            model(xi, yi, em, ea);
            run_req(xi, yi, m, a, lat);
            check("rand_mag",   longint'(m), longint'(em), TOL);
            check("rand_angle", longint'($signed(a)), longint'(ea), TOL);
            consume();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
